// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e : FSM state codes (2 bits; code 2'b11 is unused and recovers to S_IDLE)
//   ARB_P0/ARB_P1 : port indices, also used as values of the owner/winner bits
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } arb_state_e;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the data-memory arbiter.
//   eligible_i    : [0] port 0 eligible, [1] port 1 eligible
//   last_owner_i  : port of the most recent completed access
//   p1_lock_i     : port 1 asks for back-to-back priority
//   lock_ok_i     : port 1 has not yet used up its locked grants
//   grant_valid_o : at least one port is eligible
//   winner_o      : port to grant (meaningful only when grant_valid_o=1)
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] eligible_i,
    input  logic       last_owner_i,
    input  logic       p1_lock_i,
    input  logic       lock_ok_i,
    output logic       grant_valid_o,
    output logic       winner_o
);

    always_comb begin
        grant_valid_o = |eligible_i;
        winner_o      = ARB_P0;
        if (eligible_i == 2'b11) begin
            // Lock only extends a run that port 1 already holds; otherwise
            // plain round-robin against the last owner.
            if ((last_owner_i == ARB_P1) && p1_lock_i && lock_ok_i) begin
                winner_o = ARB_P1;
            end else begin
                winner_o = ~last_owner_i;
            end
        end else begin
            winner_o = eligible_i[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of one single-port synchronous data RAM.
// Port 0 is the core load/store path, port 1 the loader / debug DMA.
//
// Handshake (both ports): the requester raises pX_req together with pX_we,
// pX_addr and pX_wdata and holds all of them until pX_ack. pX_ack is a
// single-cycle pulse; in that cycle pX_rdata carries the read result and it is
// held afterwards. A request still high in its own ack cycle is not a new
// request; it becomes eligible again one cycle later.
//
// Ports:
//   clk, arst                  clock, synchronous active-high reset
//   p0_* / p1_*                requester ports (req, we, addr, wdata, ack, rdata)
//   p1_lock                    port 1 back-to-back priority request
//   owner, busy                port of the access in flight, access in flight
//   mem_addr, mem_data_o       registered RAM address / write data
//   mem_WE                     registered RAM write enable (one-cycle pulse)
//   mem_data_i                 RAM read data, one cycle after the address
//   dbg_state_o                current FSM state code
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LOCK   = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    input  logic                  p1_lock,
    output logic                  owner,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_WE,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [1:0]            dbg_state_o
);

    localparam int              LW        = $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0]   LOCK_MAX  = LW'(MAX_LOCK);
    localparam logic [LW-1:0]   LOCK_ONE  = LW'(1);

    arb_state_e            state_q;
    logic                  owner_q;
    logic                  last_owner_q;
    logic                  acc_we_q;
    logic [LW-1:0]         lock_cnt_q;
    logic [LW-1:0]         lock_cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  mem_we_q;
    logic [1:0]            ack_q;
    logic [DATA_WIDTH-1:0] p0_rdata_q;
    logic [DATA_WIDTH-1:0] p1_rdata_q;

    logic [1:0]            eligible;
    logic                  grant_valid;
    logic                  winner;

    // A port sitting in its own ack cycle is masked out.
    assign eligible = {p1_req & ~ack_q[1], p0_req & ~ack_q[0]};

    dmem_arb_pick u_pick (
        .eligible_i    (eligible),
        .last_owner_i  (last_owner_q),
        .p1_lock_i     (p1_lock),
        .lock_ok_i     (lock_cnt_q < LOCK_MAX),
        .grant_valid_o (grant_valid),
        .winner_o      (winner)
    );

    // Locked-run length: counts port-1 completions while the lock is held,
    // any port-0 completion or a released lock starts over.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!p1_lock) begin
            lock_cnt_d = '0;
        end else if (state_q == S_DATA) begin
            if (owner_q == ARB_P0) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LOCK_MAX) begin
                lock_cnt_d = lock_cnt_q + LOCK_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q      <= S_IDLE;
            owner_q      <= ARB_P0;
            last_owner_q <= ARB_P1;
            acc_we_q     <= 1'b0;
            lock_cnt_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            ack_q        <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            ack_q      <= '0;
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        state_q     <= S_ADDR;
                        owner_q     <= winner;
                        acc_we_q    <= winner ? p1_we    : p0_we;
                        mem_we_q    <= winner ? p1_we    : p0_we;
                        mem_addr_q  <= winner ? p1_addr  : p0_addr;
                        mem_wdata_q <= winner ? p1_wdata : p0_wdata;
                    end
                end
                S_ADDR: begin
                    // RAM samples on this edge; the write strobe ends here.
                    mem_we_q <= 1'b0;
                    state_q  <= S_DATA;
                end
                S_DATA: begin
                    ack_q[owner_q] <= 1'b1;
                    if (!acc_we_q) begin
                        if (owner_q == ARB_P1) begin
                            p1_rdata_q <= mem_data_i;
                        end else begin
                            p0_rdata_q <= mem_data_i;
                        end
                    end
                    last_owner_q <= owner_q;
                    state_q      <= S_IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign p0_ack      = ack_q[0];
    assign p1_ack      = ack_q[1];
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign owner       = owner_q;
    assign busy        = (state_q == S_ADDR) || (state_q == S_DATA);
    assign mem_addr    = mem_addr_q;
    assign mem_data_o  = mem_wdata_q;
    assign mem_WE      = mem_we_q;
    assign dbg_state_o = state_q;

endmodule
